// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller for an in-order core with a multicycle FPU.
// It handles operand forwarding, load-use stalls, branch/jump flushes and
// memory back-pressure. A single-entry scoreboard tracks the one
// multicycle FPU op in flight and raises its result writeback strobe.
module pipeline_ctrl #(
    parameter int FPU_LAT = 4   // issue-to-result latency, 2..15
) (
    input  logic       clk,
    input  logic       rstn,
    // decode stage
    input  logic       d_valid,
    input  logic [4:0] d_rs1,
    input  logic [4:0] d_rs2,
    input  logic [4:0] d_rs3,
    input  logic [4:0] d_rd,
    input  logic [2:0] d_src_use,
    input  logic [2:0] d_src_fpu,
    input  logic       d_fpu_write,
    input  logic       d_fpu_mc,
    // execute stage
    input  logic [4:0] e_rs1,
    input  logic [4:0] e_rs2,
    input  logic [4:0] e_rs3,
    input  logic [4:0] e_rd,
    input  logic [2:0] e_src_fpu,
    input  logic       e_reg_write,
    input  logic       e_fpu_write,
    input  logic       e_is_load,
    input  logic       e_redirect,
    // memory and writeback stages
    input  logic [4:0] m_rd,
    input  logic [4:0] w_rd,
    input  logic       m_reg_write,
    input  logic       m_fpu_write,
    input  logic       w_reg_write,
    input  logic       w_fpu_write,
    input  logic       mem_ready,
    // pipeline register controls
    output logic       stall_f,
    output logic       stall_d,
    output logic       stall_e,
    output logic       stall_m,
    output logic       flush_d,
    output logic       flush_e,
    // execute operand selects: 00 regfile, 10 memory stage, 01 writeback
    output logic [1:0] fwd1,
    output logic [1:0] fwd2,
    output logic [1:0] fwd3,
    // multicycle FPU scoreboard
    output logic       mc_busy,
    output logic       mc_done,
    output logic [4:0] mc_rd
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(FPU_LAT - 1);

    state_t     state_q;
    logic [3:0] cnt_q;
    logic [4:0] mc_rd_q;

    logic [4:0] d_rs [3];
    logic [4:0] e_rs [3];
    logic [1:0] fwd  [3];
    logic       load_use;
    logic       sb_hazard;
    logic       issue;

    // A producer feeds a consumer when the register index matches and both
    // sit in the same file. Integer x0 is hardwired zero and never a real
    // dependency; FPU register f0 is an ordinary register.
    function automatic logic dep_match(
        input logic [4:0] rd,
        input logic       wr_int,
        input logic       wr_fpu,
        input logic [4:0] rs,
        input logic       rs_is_fpu
    );
        if (rd != rs)
            return 1'b0;
        if (rs_is_fpu)
            return wr_fpu;
        return wr_int && (rd != 5'd0);
    endfunction

    assign d_rs[0] = d_rs1;
    assign d_rs[1] = d_rs2;
    assign d_rs[2] = d_rs3;
    assign e_rs[0] = e_rs1;
    assign e_rs[1] = e_rs2;
    assign e_rs[2] = e_rs3;

    // Operand forwarding: the memory stage holds the younger result, so it wins.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            // NOTE: every always_comb output gets a value on every path (here
            // the default); a missing branch assignment would infer a latch.
            fwd[i] = 2'b00;
            if (dep_match(m_rd, m_reg_write, m_fpu_write, e_rs[i], e_src_fpu[i]))
                fwd[i] = 2'b10;
            else if (dep_match(w_rd, w_reg_write, w_fpu_write, e_rs[i], e_src_fpu[i]))
                fwd[i] = 2'b01;
        end
    end

    assign fwd1 = fwd[0];
    assign fwd2 = fwd[1];
    assign fwd3 = fwd[2];

    // Hazard detection: a used decode operand waiting on a load in execute, or
    // on the result of the multicycle op in flight.
    always_comb begin
        load_use  = 1'b0;
        sb_hazard = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (d_src_use[i] && dep_match(e_rd, e_reg_write, e_fpu_write, d_rs[i], d_src_fpu[i]))
                load_use = 1'b1;
            if (d_src_use[i] && d_src_fpu[i] && (d_rs[i] == mc_rd_q))
                sb_hazard = 1'b1;
        end
        // The scoreboard holds only one op, so a second multicycle op waits,
        // and so does a write to the same register (write-after-write).
        if (d_fpu_write && (d_rd == mc_rd_q))
            sb_hazard = 1'b1;
        if (d_fpu_mc)
            sb_hazard = 1'b1;
        load_use  = load_use && e_is_load && d_valid;
        sb_hazard = sb_hazard && d_valid && (state_q == BUSY);
    end

    // Pipeline controls: memory back-pressure freezes everything, then a
    // redirect discards the wrong-path instructions, then hazard bubbles.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (!mem_ready) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
        end else if (e_redirect) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (load_use || sb_hazard) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    // A multicycle op issues only when it really leaves decode this cycle.
    assign issue   = d_valid && d_fpu_mc && !stall_d && !flush_d;
    assign mc_done = (state_q == BUSY) && (cnt_q == 4'd0) && !w_fpu_write;
    assign mc_busy = (state_q == BUSY);
    assign mc_rd   = mc_rd_q;

    // Scoreboard FSM: the countdown runs regardless of pipeline stalls, and a
    // redirect never cancels an op because it has already left execute.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            mc_rd_q <= 5'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its pre-edge value, independent of statement order.
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        state_q <= BUSY;
                        cnt_q   <= CNT_LOAD;
                        mc_rd_q <= d_rd;
                    end
                end
                BUSY: begin
                    if (mc_done) begin
                        if (issue) begin
                            cnt_q   <= CNT_LOAD;
                            mc_rd_q <= d_rd;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl with FPU_LAT=4: a table of
// combinational vectors plus directed multicycle sequences.
module tb_pipeline_ctrl;

    typedef struct packed {
        logic       d_valid;
        logic [4:0] d_rs1, d_rs2, d_rs3, d_rd;
        logic [2:0] d_src_use, d_src_fpu;
        logic       d_fpu_write, d_fpu_mc;
        logic [4:0] e_rs1, e_rs2, e_rs3, e_rd;
        logic [2:0] e_src_fpu;
        logic       e_reg_write, e_fpu_write, e_is_load, e_redirect;
        logic [4:0] m_rd, w_rd;
        logic       m_reg_write, m_fpu_write, w_reg_write, w_fpu_write;
        logic       mem_ready;
    } in_t;

    typedef struct packed {
        in_t        i;
        logic [3:0] stall;   // {f, d, e, m}
        logic [1:0] flush;   // {d, e}
        logic [1:0] f1, f2, f3;
    } vec_t;

    logic       clk, rstn;
    logic       d_valid, d_fpu_write, d_fpu_mc;
    logic [4:0] d_rs1, d_rs2, d_rs3, d_rd;
    logic [2:0] d_src_use, d_src_fpu;
    logic [4:0] e_rs1, e_rs2, e_rs3, e_rd;
    logic [2:0] e_src_fpu;
    logic       e_reg_write, e_fpu_write, e_is_load, e_redirect;
    logic [4:0] m_rd, w_rd;
    logic       m_reg_write, m_fpu_write, w_reg_write, w_fpu_write, mem_ready;
    logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
    logic [1:0] fwd1, fwd2, fwd3;
    logic       mc_busy, mc_done;
    logic [4:0] mc_rd;

    int checks   = 0;
    int failures = 0;

    pipeline_ctrl #(.FPU_LAT(4)) dut (
        .clk(clk), .rstn(rstn),
        .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rs3(d_rs3), .d_rd(d_rd),
        .d_src_use(d_src_use), .d_src_fpu(d_src_fpu),
        .d_fpu_write(d_fpu_write), .d_fpu_mc(d_fpu_mc),
        .e_rs1(e_rs1), .e_rs2(e_rs2), .e_rs3(e_rs3), .e_rd(e_rd), .e_src_fpu(e_src_fpu),
        .e_reg_write(e_reg_write), .e_fpu_write(e_fpu_write),
        .e_is_load(e_is_load), .e_redirect(e_redirect),
        .m_rd(m_rd), .w_rd(w_rd),
        .m_reg_write(m_reg_write), .m_fpu_write(m_fpu_write),
        .w_reg_write(w_reg_write), .w_fpu_write(w_fpu_write),
        .mem_ready(mem_ready),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e),
        .fwd1(fwd1), .fwd2(fwd2), .fwd3(fwd3),
        .mc_busy(mc_busy), .mc_done(mc_done), .mc_rd(mc_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t base();
        in_t x;
        x = '0;
        x.mem_ready = 1'b1;
        return x;
    endfunction

    task automatic apply(input in_t x);
        d_valid     = x.d_valid;     d_rs1 = x.d_rs1; d_rs2 = x.d_rs2; d_rs3 = x.d_rs3;
        d_rd        = x.d_rd;        d_src_use = x.d_src_use; d_src_fpu = x.d_src_fpu;
        d_fpu_write = x.d_fpu_write; d_fpu_mc = x.d_fpu_mc;
        e_rs1       = x.e_rs1;       e_rs2 = x.e_rs2; e_rs3 = x.e_rs3; e_rd = x.e_rd;
        e_src_fpu   = x.e_src_fpu;   e_reg_write = x.e_reg_write; e_fpu_write = x.e_fpu_write;
        e_is_load   = x.e_is_load;   e_redirect = x.e_redirect;
        m_rd        = x.m_rd;        w_rd = x.w_rd;
        m_reg_write = x.m_reg_write; m_fpu_write = x.m_fpu_write;
        w_reg_write = x.w_reg_write; w_fpu_write = x.w_fpu_write;
        mem_ready   = x.mem_ready;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_ctrl(input string name, input logic [3:0] st, input logic [1:0] fl);
        check({name, "_stall"}, {28'd0, stall_f, stall_d, stall_e, stall_m}, {28'd0, st});
        check({name, "_flush"}, {30'd0, flush_d, flush_e}, {30'd0, fl});
    endtask

    task automatic check_sb(input string name, input logic busy, input logic done);
        check({name, "_busy"}, {31'd0, mc_busy}, {31'd0, busy});
        check({name, "_done"}, {31'd0, mc_done}, {31'd0, done});
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t vec [14];
    in_t  x;
    in_t  lu;

    initial begin
        // ---------------- combinational vector table ----------------
        for (int k = 0; k < 14; k++) begin
            vec[k]   = '0;
            vec[k].i = base();
        end
        // M and W both write f7: M wins
        vec[1].i.m_rd = 7; vec[1].i.w_rd = 7; vec[1].i.m_fpu_write = 1; vec[1].i.w_fpu_write = 1;
        vec[1].i.e_rs2 = 7; vec[1].i.e_src_fpu = 3'b010; vec[1].f2 = 2'b10;
        // M writes integer x7 only: FPU operand takes W, integer operand takes M
        vec[2].i.m_rd = 7; vec[2].i.m_reg_write = 1; vec[2].i.w_rd = 7; vec[2].i.w_fpu_write = 1;
        vec[2].i.e_rs1 = 7; vec[2].i.e_rs2 = 7; vec[2].i.e_src_fpu = 3'b010;
        vec[2].f1 = 2'b10; vec[2].f2 = 2'b01;
        // integer x5 in M and W; operand 3 is in the FPU file so it matches neither
        vec[3].i.m_rd = 5; vec[3].i.m_reg_write = 1; vec[3].i.w_rd = 5; vec[3].i.w_reg_write = 1;
        vec[3].i.e_rs1 = 5; vec[3].i.e_rs2 = 5; vec[3].i.e_rs3 = 5; vec[3].i.e_src_fpu = 3'b100;
        vec[3].f1 = 2'b10; vec[3].f2 = 2'b10;
        // integer x0 never forwards, FPU f0 does
        vec[4].i.m_reg_write = 1; vec[4].i.w_fpu_write = 1; vec[4].i.e_src_fpu = 3'b010;
        vec[4].f2 = 2'b01;
        // W-only integer match on operand 3
        vec[5].i.w_rd = 9; vec[5].i.w_reg_write = 1; vec[5].i.e_rs3 = 9; vec[5].f3 = 2'b01;
        // load-use on x5
        lu = base();
        lu.e_is_load = 1; lu.e_reg_write = 1; lu.e_rd = 5;
        lu.d_valid = 1; lu.d_rs1 = 5; lu.d_src_use = 3'b001;
        vec[6].i = lu; vec[6].stall = 4'b1100; vec[6].flush = 2'b01;
        // load to x0: no stall
        vec[7].i = lu; vec[7].i.e_rd = 0; vec[7].i.d_rs1 = 0;
        // matching operand is not used
        vec[8].i = lu; vec[8].i.d_rs1 = 3; vec[8].i.d_rs2 = 5;
        // integer load, FPU-file source: different files
        vec[9].i = lu; vec[9].i.d_src_fpu = 3'b001;
        // FPU load to f0 feeding operand 3
        vec[10].i = base(); vec[10].i.e_is_load = 1; vec[10].i.e_fpu_write = 1;
        vec[10].i.d_valid = 1; vec[10].i.d_src_use = 3'b100; vec[10].i.d_src_fpu = 3'b100;
        vec[10].stall = 4'b1100; vec[10].flush = 2'b01;
        // redirect beats load-use
        vec[11].i = lu; vec[11].i.e_redirect = 1; vec[11].flush = 2'b11;
        // memory back-pressure beats redirect and load-use
        vec[12].i = lu; vec[12].i.e_redirect = 1; vec[12].i.mem_ready = 0; vec[12].stall = 4'b1111;
        // nothing valid in decode
        vec[13].i = lu; vec[13].i.d_valid = 0;

        // ---------------- reset ----------------
        rstn = 1'b0;
        apply(base());
        #1;
        check_sb("reset", 1'b0, 1'b0);
        check("reset_mc_rd", {27'd0, mc_rd}, 32'd0);
        #21;
        rstn = 1'b1;
        next_cycle();

        // ---------------- table ----------------
        for (int k = 0; k < 14; k++) begin
            apply(vec[k].i);
            #1;
            check_ctrl($sformatf("vec%0d", k), vec[k].stall, vec[k].flush);
            check($sformatf("vec%0d_fwd", k), {26'd0, fwd1, fwd2, fwd3},
                  {26'd0, vec[k].f1, vec[k].f2, vec[k].f3});
            #1;
        end

        // ---------------- load-use then forward from M ----------------
        next_cycle();
        apply(lu);
        #1;
        check_ctrl("lu_cyc0", 4'b1100, 2'b01);
        next_cycle();
        x = base(); x.m_rd = 5; x.m_reg_write = 1; x.e_rs1 = 5;
        apply(x);
        #1;
        check_ctrl("lu_cyc1", 4'b0000, 2'b00);
        check("lu_cyc1_fwd1", {30'd0, fwd1}, {30'd0, 2'b10});

        // ---------------- issue f3, dependent reader stalls ----------------
        next_cycle();
        x = base(); x.d_valid = 1; x.d_fpu_mc = 1; x.d_fpu_write = 1; x.d_rd = 3;
        apply(x);
        #1;
        check_ctrl("mc_issue", 4'b0000, 2'b00);
        check_sb("mc_issue", 1'b0, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            x = base(); x.d_valid = 1; x.d_rs1 = 3; x.d_src_use = 3'b001; x.d_src_fpu = 3'b001;
            apply(x);
            #1;
            check_sb($sformatf("mc_c%0d", c), c <= 4, c == 4);
            check_ctrl($sformatf("mc_c%0d", c), (c <= 4) ? 4'b1100 : 4'b0000,
                       (c <= 4) ? 2'b01 : 2'b00);
            if (c <= 4)
                check($sformatf("mc_c%0d_rd", c), {27'd0, mc_rd}, 32'd3);
        end

        // ---------------- deferred done, redirect does not cancel ----------------
        next_cycle();
        x = base(); x.d_valid = 1; x.d_fpu_mc = 1; x.d_fpu_write = 1; x.d_rd = 4;
        apply(x);
        for (int c = 1; c <= 7; c++) begin
            next_cycle();
            x = base();
            case (c)
                1: begin x.d_valid = 1; x.d_fpu_mc = 1; x.d_rd = 9; end
                2: begin x.d_valid = 1; x.d_fpu_write = 1; x.d_rd = 4; end
                3: begin x.d_valid = 1; x.d_fpu_mc = 1; x.d_rd = 9; x.e_redirect = 1; end
                4, 5: x.w_fpu_write = 1;
                default: ;
            endcase
            apply(x);
            #1;
            check_sb($sformatf("defer_c%0d", c), c <= 6, c == 6);
            if (c <= 2)
                check_ctrl($sformatf("defer_c%0d", c), 4'b1100, 2'b01);
            if (c == 3)
                check_ctrl("defer_c3", 4'b0000, 2'b11);
            if (c == 6)
                check("defer_c6_rd", {27'd0, mc_rd}, 32'd4);
        end

        // ---------------- back-pressure with redirect and load-use ----------------
        next_cycle();
        x = lu; x.e_redirect = 1; x.mem_ready = 0; x.d_fpu_mc = 1; x.d_rd = 6;
        apply(x);
        #1;
        check_ctrl("mem_hold", 4'b1111, 2'b00);
        next_cycle();
        x.mem_ready = 1;
        apply(x);
        #1;
        check_ctrl("mem_release", 4'b0000, 2'b11);
        check_sb("mem_release", 1'b0, 1'b0);
        next_cycle();
        apply(base());
        #1;
        check_sb("mem_after", 1'b0, 1'b0);

        // ---------------- reset mid-BUSY ----------------
        next_cycle();
        x = base(); x.d_valid = 1; x.d_fpu_mc = 1; x.d_fpu_write = 1; x.d_rd = 2;
        apply(x);
        next_cycle();
        apply(base());
        next_cycle();
        #1;
        check_sb("rst_pre", 1'b1, 1'b0);
        #1;
        rstn = 1'b0;
        #1;
        check_sb("rst_async", 1'b0, 1'b0);
        check("rst_async_rd", {27'd0, mc_rd}, 32'd0);
        apply(lu);
        #1;
        check_ctrl("rst_comb", 4'b1100, 2'b01);
        x = base(); x.d_valid = 1; x.d_fpu_mc = 1; x.d_rd = 8;
        apply(x);
        next_cycle();
        next_cycle();
        apply(base());
        #2;
        rstn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            #1;
            check_sb($sformatf("rst_post%0d", c), 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
